display_scheduler: RTL and testbench

//   Shares the six-digit HEX display between the operational FSM, the setup FSM and timed

---
 rtl/display_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_display_scheduler.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/display_scheduler.sv
// Arbitrates the six-digit HEX display between operational, setup and timed-message sources.
// Packet latency 1 clk from req_x; message held MSG_HOLD_CYC cycles; msg_valid stalls while msg_ready=0.
// Optional DISPLAY_BLINK_EN: message blinks with half-period BLINK_HALF_CYC.

package display_scheduler_pkg;
    typedef logic [5:0][3:0] bcdPac_t;
    localparam bcdPac_t BCD_BLANK = {6{4'hB}};
endpackage

module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int MSG_HOLD_CYC   = 100_000_000,
    parameter int BLINK_HALF_CYC = 25_000_000
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    req_o,
    input  bcdPac_t bcd_o,
    input  logic    req_s,
    input  bcdPac_t bcd_s,
    input  logic    setup_active,
    input  logic    msg_valid,
    input  bcdPac_t msg_bcd,
    output logic    msg_ready,
    output logic    msg_done,
    output logic    enable_o,
    output logic    enable_s,
    output bcdPac_t bcd_packet_operacional,
    output bcdPac_t bcd_packet_setup
);

    localparam int MAX_CYC = (MSG_HOLD_CYC > BLINK_HALF_CYC) ? MSG_HOLD_CYC : BLINK_HALF_CYC;
    localparam int TW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPER,
        ST_SETUP,
        ST_GAP,
        ST_MSG
    } state_t;

    state_t          state_q, state_d;
    state_t          tgt;
    logic [TW-1:0]   timer_q, timer_d;
    logic            seen_o_q, seen_o_d;
    logic            msg_ch_q, msg_ch_d;     // 1 = message rides the setup channel
    logic            msg_done_q, msg_done_d;
    logic            accept;
    logic            msg_visible;
    bcdPac_t         pkt_o_q, pkt_o_d;
    bcdPac_t         pkt_s_q, pkt_s_d;
    bcdPac_t         msg_pkt_q, msg_pkt_d;
    bcdPac_t         out_o_q, out_o_d;
    bcdPac_t         out_s_q, out_s_d;

    always_comb begin
        if (setup_active) begin
            tgt = ST_SETUP;
        end else if (seen_o_q) begin
            tgt = ST_OPER;
        end else begin
            tgt = ST_IDLE;
        end
    end

    assign msg_ready = (state_q != ST_MSG) && (state_q != ST_GAP);
    assign accept    = msg_valid && msg_ready;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        msg_ch_d   = msg_ch_q;
        msg_pkt_d  = msg_pkt_q;
        msg_done_d = 1'b0;
        seen_o_d   = seen_o_q | req_o;
        pkt_o_d    = req_o ? bcd_o : pkt_o_q;
        pkt_s_d    = req_s ? bcd_s : pkt_s_q;

        case (state_q)
            ST_IDLE, ST_OPER, ST_SETUP: begin
                if (accept) begin
                    state_d   = ST_MSG;
                    timer_d   = TW'(MSG_HOLD_CYC - 1);
                    msg_ch_d  = (state_q == ST_SETUP);
                    msg_pkt_d = msg_bcd;
                end else if (state_q == ST_IDLE) begin
                    state_d = tgt;
                end else if (state_q == ST_OPER) begin
                    if (tgt == ST_SETUP) state_d = ST_GAP;
                end else begin
                    // seen_o is sticky, so SETUP only ever hands over to OPER
                    if (tgt == ST_OPER) state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = tgt;
            end
            ST_MSG: begin
                if (timer_q == '0) begin
                    msg_done_d = 1'b1;
                    if (tgt == ST_IDLE) begin
                        state_d = ST_IDLE;
                    end else if ((tgt == ST_SETUP) == msg_ch_q) begin
                        state_d = tgt;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        out_o_d = ((state_d == ST_MSG) && !msg_ch_d) ? msg_pkt_d : pkt_o_d;
        out_s_d = ((state_d == ST_MSG) &&  msg_ch_d) ? msg_pkt_d : pkt_s_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            seen_o_q   <= 1'b0;
            msg_ch_q   <= 1'b0;
            msg_done_q <= 1'b0;
            pkt_o_q    <= BCD_BLANK;
            pkt_s_q    <= BCD_BLANK;
            msg_pkt_q  <= BCD_BLANK;
            out_o_q    <= BCD_BLANK;
            out_s_q    <= BCD_BLANK;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            seen_o_q   <= seen_o_d;
            msg_ch_q   <= msg_ch_d;
            msg_done_q <= msg_done_d;
            pkt_o_q    <= pkt_o_d;
            pkt_s_q    <= pkt_s_d;
            msg_pkt_q  <= msg_pkt_d;
            out_o_q    <= out_o_d;
            out_s_q    <= out_s_d;
        end
    end

`ifdef DISPLAY_BLINK_EN
    logic          blink_vis_q, blink_vis_d;
    logic [TW-1:0] blink_cnt_q, blink_cnt_d;

    // Phase restarts visible on every accept; it only advances while the message is up.
    always_comb begin
        blink_vis_d = blink_vis_q;
        blink_cnt_d = blink_cnt_q;
        if (accept) begin
            blink_vis_d = 1'b1;
            blink_cnt_d = TW'(BLINK_HALF_CYC - 1);
        end else if (state_q == ST_MSG) begin
            if (blink_cnt_q == '0) begin
                blink_vis_d = ~blink_vis_q;
                blink_cnt_d = TW'(BLINK_HALF_CYC - 1);
            end else begin
                blink_cnt_d = blink_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_vis_q <= 1'b1;
            blink_cnt_q <= '0;
        end else begin
            blink_vis_q <= blink_vis_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign msg_visible = blink_vis_q;
`else
    assign msg_visible = 1'b1;
`endif

    assign enable_o = (state_q == ST_OPER)  || ((state_q == ST_MSG) && !msg_ch_q && msg_visible);
    assign enable_s = (state_q == ST_SETUP) || ((state_q == ST_MSG) &&  msg_ch_q && msg_visible);

    assign msg_done               = msg_done_q;
    assign bcd_packet_operacional = out_o_q;
    assign bcd_packet_setup       = out_s_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed and randomized bench for display_scheduler against a cycle-level behavioural model.
module tb_display_scheduler;
    import display_scheduler_pkg::*;

    localparam int HOLD = 8;
    localparam int HALF = 2;
    localparam int M_IDLE = 0, M_OPER = 1, M_SETUP = 2, M_GAP = 3, M_MSG = 4;

    logic    clk = 1'b0;
    logic    rst;
    logic    req_o, req_s, setup_active, msg_valid;
    bcdPac_t bcd_o, bcd_s, msg_bcd;
    logic    msg_ready, msg_done, enable_o, enable_s;
    bcdPac_t bcd_packet_operacional, bcd_packet_setup;

    always #5 clk = ~clk;

    display_scheduler #(.MSG_HOLD_CYC(HOLD), .BLINK_HALF_CYC(HALF)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .req_o                  (req_o),
        .bcd_o                  (bcd_o),
        .req_s                  (req_s),
        .bcd_s                  (bcd_s),
        .setup_active           (setup_active),
        .msg_valid              (msg_valid),
        .msg_bcd                (msg_bcd),
        .msg_ready              (msg_ready),
        .msg_done               (msg_done),
        .enable_o               (enable_o),
        .enable_s               (enable_s),
        .bcd_packet_operacional (bcd_packet_operacional),
        .bcd_packet_setup       (bcd_packet_setup)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the display, how many message cycles remain, what each shadow holds.
    int      m_mode, m_left;
    bit      m_ch_setup, m_seen, m_done, m_acc;
    bcdPac_t m_sho, m_shs, m_msg;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_left = 0; m_ch_setup = 0; m_seen = 0; m_done = 0; m_acc = 0;
        m_sho = BCD_BLANK; m_shs = BCD_BLANK; m_msg = BCD_BLANK;
    endtask

    task automatic model_edge();
        int owner;
        m_acc = 0;
        if (rst) begin
            model_reset();
            return;
        end
        owner  = setup_active ? M_SETUP : (m_seen ? M_OPER : M_IDLE);
        m_done = 0;
        if (m_mode == M_MSG) begin
            if (m_left == 0) begin
                m_done = 1;
                if (owner == M_IDLE || ((owner == M_SETUP) == m_ch_setup)) m_mode = owner;
                else m_mode = M_GAP;
            end else begin
                m_left = m_left - 1;
            end
        end else if (m_mode == M_GAP) begin
            m_mode = owner;
        end else if (msg_valid) begin
            m_acc      = 1;
            m_ch_setup = (m_mode == M_SETUP);
            m_msg      = msg_bcd;
            m_left     = HOLD - 1;
            m_mode     = M_MSG;
        end else if (m_mode == M_IDLE) begin
            m_mode = owner;
        end else if (owner != M_IDLE && owner != m_mode) begin
            m_mode = M_GAP;
        end
        if (req_o) begin m_sho = bcd_o; m_seen = 1; end
        if (req_s) m_shs = bcd_s;
    endtask

    task automatic check_all();
        bit vis, in_msg;
        in_msg = (m_mode == M_MSG);
`ifdef DISPLAY_BLINK_EN
        vis = (((HOLD - 1 - m_left) / HALF) % 2) == 0;
`else
        vis = 1;
`endif
        chk("enable_o", 24'(enable_o), 24'((m_mode == M_OPER) || (in_msg && !m_ch_setup && vis)));
        chk("enable_s", 24'(enable_s), 24'((m_mode == M_SETUP) || (in_msg && m_ch_setup && vis)));
        chk("pkt_oper", bcd_packet_operacional, (in_msg && !m_ch_setup) ? m_msg : m_sho);
        chk("pkt_setup", bcd_packet_setup, (in_msg && m_ch_setup) ? m_msg : m_shs);
        chk("msg_ready", 24'(msg_ready), 24'(m_mode != M_MSG && m_mode != M_GAP));
        chk("msg_done", 24'(msg_done), 24'(m_done));
        chk("excl_en", 24'(enable_o & enable_s), 24'(0));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; req_o = 0; req_s = 0; setup_active = 0; msg_valid = 0;
        bcd_o = BCD_BLANK; bcd_s = BCD_BLANK; msg_bcd = BCD_BLANK;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("reset_pkt", bcd_packet_operacional, 24'hBBBBBB);
        rst = 1'b0;

        // Idle: nothing requested, display stays dark
        repeat (20) cycle();
        chk("idle_ready", 24'(msg_ready), 24'(1));

        // Operational packet appears one clock after its strobe
        bcd_o = 24'h123456; req_o = 1; cycle(); req_o = 0;
        chk("oper_lat1", bcd_packet_operacional, 24'h123456);
        repeat (2) cycle();
        chk("oper_en", 24'({enable_o, enable_s}), 24'(2'b10));

        // Hand over to setup: one dark cycle, then setup shadow shown
        bcd_s = 24'h987654; req_s = 1; cycle(); req_s = 0;
        setup_active = 1; cycle();
        chk("gap_en", 24'({enable_o, enable_s}), 24'(2'b00));
        cycle();
        chk("setup_en", 24'({enable_o, enable_s}), 24'(2'b01));
        chk("setup_pkt", bcd_packet_setup, 24'h987654);

        // Back to operational, then a message on the operational channel
        setup_active = 0; repeat (3) cycle();
        msg_bcd = 24'hAAAAAA; msg_valid = 1; cycle(); msg_valid = 0;
        chk("msg_pkt", bcd_packet_operacional, 24'hAAAAAA);
        chk("msg_busy", 24'(msg_ready), 24'(0));
        repeat (10) cycle();
        chk("msg_restore", bcd_packet_operacional, 24'h123456);

        // Setup takes over during a message: exit goes through the gap into setup
        msg_bcd = 24'hA1A2A3; msg_valid = 1; cycle(); msg_valid = 0;
        repeat (2) cycle();
        setup_active = 1; bcd_s = 24'h000000; req_s = 1; cycle(); req_s = 0;
        repeat (10) cycle();
        chk("setup_after_msg", bcd_packet_setup, 24'h000000);
        chk("setup_after_en", 24'(enable_s), 24'(1));

        // Message on the setup channel, cut short by reset
        msg_bcd = 24'hB0B1B2; msg_valid = 1; cycle(); msg_valid = 0;
        repeat (3) cycle();
        rst = 1'b1; #1;
        model_reset();
        check_all();
        chk("rst_mid_msg_done", 24'(msg_done), 24'(0));
        cycle();
        rst = 1'b0;
        repeat (4) cycle();

        // Randomized traffic
        setup_active = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(19) == 0) setup_active = ~setup_active;
            if (!msg_valid && $urandom_range(5) == 0) begin
                msg_valid = 1;
                msg_bcd   = 24'($urandom);
            end
            req_o = ($urandom_range(4) == 0); bcd_o = 24'($urandom);
            req_s = ($urandom_range(4) == 0); bcd_s = 24'($urandom);
            cycle();
            if (m_acc) msg_valid = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
